// File: rtl/dco_ramp_ctrl.sv
// DCO tuning-word sequencer: slews speed_var toward a commanded target in
// bounded steps at a programmable interval, then holds for a settle period.
module dco_ramp_ctrl #(
  parameter int unsigned          bit_count     = 24,
  parameter int unsigned          div_width     = 16,
  parameter int unsigned          settle_cycles = 8,
  parameter logic [bit_count-1:0] reset_word    = '0
) (
  input  logic                 sys_clk,
  input  logic                 ext_rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [bit_count-1:0] cmd_target,
  input  logic [bit_count-1:0] cmd_step,
  input  logic [div_width-1:0] tick_div,
  input  logic                 abort,
  output logic [bit_count-1:0] speed_var,
  output logic                 ramping,
  output logic                 settled,
  output logic                 done
);

  localparam int unsigned SW = (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(settle_cycles - 1);
  localparam logic [bit_count-1:0] ONE = {{(bit_count-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RAMP, SETTLE} state_t;

  typedef struct packed {
    logic [bit_count-1:0] target;
    logic [bit_count-1:0] step;
    logic [div_width-1:0] div;
  } cmd_t;

  state_t               state_q, state_d;
  cmd_t                 cmd_q, cmd_d;
  logic [bit_count-1:0] spd_q, spd_d;
  logic [div_width-1:0] tick_q, tick_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic                 settled_q, settled_d;
  logic                 done_q, done_d;
  logic [bit_count-1:0] diff;

  always_ff @(posedge sys_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      state_q   <= IDLE;
      cmd_q     <= '{target: reset_word, step: '0, div: '0};
      spd_q     <= reset_word;
      tick_q    <= '0;
      settle_q  <= '0;
      settled_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      spd_q     <= spd_d;
      tick_q    <= tick_d;
      settle_q  <= settle_d;
      settled_q <= settled_d;
      done_q    <= done_d;
    end
  end

  // Larger-minus-smaller keeps the distance unsigned and wrap-free, so a step
  // is only applied when it cannot overshoot the target.
  assign diff = (cmd_q.target >= spd_q) ? (cmd_q.target - spd_q)
                                        : (spd_q - cmd_q.target);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    spd_d     = spd_q;
    tick_d    = tick_q;
    settle_d  = settle_q;
    settled_d = settled_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d.target = cmd_target;
          cmd_d.step   = (cmd_step == '0) ? ONE : cmd_step;
          cmd_d.div    = tick_div;
          tick_d       = tick_div;
          settled_d    = 1'b0;
          state_d      = RAMP;
        end
      end
      RAMP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tick_q != '0) begin
          tick_d = tick_q - 1'b1;
        end else begin
          tick_d = cmd_q.div;
          if (diff <= cmd_q.step) begin
            spd_d    = cmd_q.target;
            settle_d = SETTLE_LOAD;
            state_d  = SETTLE;
          end else if (cmd_q.target > spd_q) begin
            spd_d = spd_q + cmd_q.step;
          end else begin
            spd_d = spd_q - cmd_q.step;
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (settle_q == '0) begin
          state_d   = IDLE;
          settled_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign ramping   = (state_q == RAMP);
  assign speed_var = spd_q;
  assign settled   = settled_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dco_ramp_ctrl.sv
// Scoreboard bench for dco_ramp_ctrl: a ramp model predicts every speed_var
// change and done pulse with its edge number; a monitor pops and compares.
module tb_dco_ramp_ctrl;
  localparam int BW = 24, DW = 16, SETTLE = 8;
  localparam logic [BW-1:0] RST_W = '0;

  typedef struct {
    int          cyc;
    logic [BW-1:0] val;
    bit          is_done;
  } ev_t;

  logic          sys_clk = 1'b0, ext_rst_n = 1'b0, cmd_valid = 1'b0, abort = 1'b0;
  logic [BW-1:0] cmd_target = '0, cmd_step = '0;
  logic [DW-1:0] tick_div = '0;
  logic          cmd_ready, ramping, settled, done;
  logic [BW-1:0] speed_var;

  dco_ramp_ctrl #(.bit_count(BW), .div_width(DW), .settle_cycles(SETTLE), .reset_word(RST_W)) dut (
    .sys_clk(sys_clk), .ext_rst_n(ext_rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_step(cmd_step), .tick_div(tick_div), .abort(abort),
    .speed_var(speed_var), .ramping(ramping), .settled(settled), .done(done));

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  ev_t q[$];
  ev_t plan_q[$];
  logic [BW-1:0] cur = RST_W, start_val;
  bit win_vld = 0;
  int rk = 0, re = 0, dn_cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cyc %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every change of speed_var and every done pulse must match the head of the queue.
  logic [BW-1:0] prev;
  ev_t me;
  always @(negedge sys_clk) begin
    if (!ext_rst_n) begin
      prev = speed_var;
    end else begin
      if (speed_var !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL step_unexpected: cyc %0d got %0h expected no change", cyc, speed_var);
        end else begin
          me = q.pop_front();
          if (me.is_done || me.cyc != cyc || me.val !== speed_var) begin
            errors++;
            $display("FAIL step: cyc %0d got %0h expected %0h at cyc %0d (done_ev=%0d)",
                     cyc, speed_var, me.val, me.cyc, me.is_done);
          end
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: cyc %0d got done=1 expected 0", cyc);
        end else begin
          me = q.pop_front();
          if (!me.is_done || me.cyc != cyc || me.val !== speed_var || settled !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL done: cyc %0d got spd=%0h settled=%0b ready=%0b expected done at cyc %0d spd=%0h settled=1 ready=1",
                     cyc, speed_var, settled, cmd_ready, me.cyc, me.val);
          end
        end
      end
      chk("ramping", ramping, longint'(win_vld && cyc >= rk && cyc < re));
      prev = speed_var;
    end
  end

  // Reference: N = ceil(|d|/step) steps of tick_div+1 cycles, last one lands on target.
  task automatic issue(input logic [BW-1:0] tgt, input logic [BW-1:0] stp,
                       input logic [DW-1:0] dv, input bit ab_same, output int k);
    longint d, s, v, pv;
    int n, per, guard;
    ev_t e;
    guard = 0;
    k = 0;
    @(negedge sys_clk);
    while (!cmd_ready && guard < 5000) begin
      @(negedge sys_clk);
      guard++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got cmd_ready=0 expected 1 within 5000 cycles");
      return;
    end
    k = cyc + 1;
    per = int'(dv) + 1;
    d = (tgt >= cur) ? longint'(tgt) - longint'(cur) : longint'(cur) - longint'(tgt);
    s = (stp == '0) ? 1 : longint'(stp);
    n = (d == 0) ? 1 : int'((d + s - 1) / s);
    plan_q.delete();
    pv = longint'(cur);
    for (int i = 1; i <= n; i++) begin
      if (i == n) v = longint'(tgt);
      else if (tgt > cur) v = longint'(cur) + i * s;
      else v = longint'(cur) - i * s;
      if (v != pv) begin
        e.cyc = k + i * per; e.val = v[BW-1:0]; e.is_done = 0;
        q.push_back(e);
        plan_q.push_back(e);
      end
      pv = v;
    end
    dn_cyc = k + n * per + SETTLE;
    e.cyc = dn_cyc; e.val = tgt; e.is_done = 1;
    q.push_back(e);
    rk = k; re = k + n * per; win_vld = 1;
    start_val = cur;
    cur = tgt;
    cmd_valid = 1'b1; cmd_target = tgt; cmd_step = stp; tick_div = dv; abort = ab_same;
    @(negedge sys_clk);
    cmd_valid = 1'b0; abort = 1'b0;
    cmd_target = $urandom_range(0, 1000); cmd_step = $urandom_range(0, 1000);
    chk("settled_clear", settled, 0);
  endtask

  task automatic bp_pulse();
    cmd_valid = 1'b1; cmd_target = $urandom_range(0, 65535); cmd_step = $urandom_range(0, 3);
    tick_div = $urandom_range(0, 7);
    chk("ready_busy", cmd_ready, 0);
    @(negedge sys_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic abort_at(input int a);
    ev_t keep[$];
    while (cyc < a - 1) @(negedge sys_clk);
    abort = 1'b1;
    if (re > a) re = a;
    foreach (q[i]) if (q[i].cyc < a && !q[i].is_done) keep.push_back(q[i]);
    q = keep;
    cur = start_val;
    foreach (plan_q[i]) if (plan_q[i].cyc < a) cur = plan_q[i].val;
    @(negedge sys_clk);
    abort = 1'b0;
    chk("abort_hold", speed_var, cur);
    chk("abort_settled", settled, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_done", done, 0);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge sys_clk);
    while (!(q.size() == 0 && cmd_ready) && guard < 5000) begin
      @(negedge sys_clk);
      guard++;
    end
    chk("idle_timeout", longint'(q.size() == 0 && cmd_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, tmpi, n, dv;
    logic [BW-1:0] t, s;
    longint d;
    #12;
    chk("rst_speed", speed_var, RST_W);
    chk("rst_settled", settled, 1);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_ramping", ramping, 0);
    @(negedge sys_clk); #1 ext_rst_n = 1'b1;

    issue(24'd100, 24'd30, 16'd0, 0, k); wait_idle();
    chk("up_settled", settled, 1);
    issue(24'd10, 24'd40, 16'd3, 0, k); bp_pulse(); wait_idle();
    chk("down_final", speed_var, 10);
    issue(24'd0, 24'hFFFFFF, 16'd0, 0, k); wait_idle();
    issue(24'd3, 24'd0, 16'd0, 0, k); wait_idle();
    issue(24'd3, 24'd7, 16'd1, 0, k); wait_idle();
    issue(24'hF00000, 24'hF00000, 16'd0, 0, k); wait_idle();
    issue(24'hFFFFFF, 24'h100000, 16'd0, 0, k); wait_idle();
    chk("top_end", speed_var, 24'hFFFFFF);

    issue(24'd0, 24'hFFFFFF, 16'd0, 0, k); wait_idle();
    issue(24'd200, 24'd30, 16'd0, 0, k); bp_pulse(); abort_at(k + 3);
    chk("abort_at_60", speed_var, 60);
    issue(24'd500, 24'd100, 16'd1, 1, k); wait_idle();

    // Asynchronous reset in the middle of SETTLE
    issue(24'd900, 24'd300, 16'd0, 0, k);
    while (cyc < re + 2) @(negedge sys_clk);
    @(posedge sys_clk); #2 ext_rst_n = 1'b0;
    #1;
    chk("mid_rst_speed", speed_var, RST_W);
    chk("mid_rst_settled", settled, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    q.delete(); win_vld = 0; cur = RST_W;
    repeat (2) @(negedge sys_clk);
    #2 ext_rst_n = 1'b1;
    issue(24'd77, 24'd20, 16'd2, 0, k); wait_idle();

    for (int it = 0; it < 40; it++) begin
      tmpi = $urandom();
      case ($urandom_range(0, 3))
        0: t = tmpi[BW-1:0];
        1: t = '0;
        2: t = '1;
        default: begin tmpi = int'(cur) + $urandom_range(0, 6) - 3; t = tmpi[BW-1:0]; end
      endcase
      d = (t >= cur) ? longint'(t) - longint'(cur) : longint'(cur) - longint'(t);
      n = $urandom_range(1, 10);
      d = (d + n - 1) / n;
      s = d[BW-1:0];
      if (d <= 8 && $urandom_range(0, 2) == 0) s = '0;
      else if ($urandom_range(0, 5) == 0) begin tmpi = $urandom(); s = tmpi[BW-1:0]; end
      dv = $urandom_range(0, 3);
      issue(t, s, dv[DW-1:0], $urandom_range(0, 3) == 0, k);
      if ($urandom_range(0, 2) == 0) bp_pulse();
      if ($urandom_range(0, 4) == 0) abort_at(k + 2 + $urandom_range(0, dn_cyc - k - 2));
      else if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
